// File: rtl/cdr_chip_slicer_if.sv
// ============================================================================
//  Module   : cdr_chip_slicer_if
//  Purpose  : Bundles the control, soft-sample and chip/word result signals
//             of the CDR chip slicer.
//  Signals  : enable, smp_valid, sample, en_dec, realign   (toward slicer)
//             chip, chip_valid, word, word_valid, sat      (from slicer)
//  Modports : master - drives samples/control, observes results
//             slave  - the slicer itself
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cdr_chip_slicer_if #(
    parameter int DATA_W = 8,
    parameter int CHIPS  = 32
);
    logic                     enable;
    logic                     smp_valid;
    logic signed [DATA_W-1:0] sample;
    logic                     en_dec;
    logic                     realign;
    logic                     chip;
    logic                     chip_valid;
    logic [CHIPS-1:0]         word;
    logic                     word_valid;
    logic                     sat;

    modport master (
        output enable, smp_valid, sample, en_dec, realign,
        input  chip, chip_valid, word, word_valid, sat
    );

    modport slave (
        input  enable, smp_valid, sample, en_dec, realign,
        output chip, chip_valid, word, word_valid, sat
    );
endinterface

`default_nettype wire

// File: rtl/cdr_chip_slicer.sv
// ============================================================================
//  Module   : cdr_chip_slicer
//  Purpose  : Integrate-and-dump of soft demodulator samples over each chip
//             period, hard slicing on every CDR decision strobe, and packing
//             of the chips into CHIPS-wide words for the despreader.
//             The first (partial) window after start-up or realign is
//             discarded; the accumulator saturates instead of wrapping.
//  Ports    : clk  - system clock
//             rst  - asynchronous active-high reset
//             bus  - cdr_chip_slicer_if.slave (samples, strobes, results)
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdr_chip_slicer #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 14,
    parameter int CHIPS  = 32
) (
    input  wire logic        clk,
    input  wire logic        rst,
    cdr_chip_slicer_if.slave bus
);

    localparam int CNT_W = (CHIPS > 1) ? $clog2(CHIPS) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(CHIPS - 1);

    // Clamp limits expressed one bit wider than the accumulator so the raw
    // sum can be compared without overflow.
    localparam logic signed [ACC_W:0] c_MAX = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] c_MIN = {2'b11, {(ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ARM  = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t                    r_state;
    logic signed [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]          r_cnt;
    logic [CHIPS-1:0]          r_shift;
    logic                      r_chip;
    logic                      r_chip_valid;
    logic [CHIPS-1:0]          r_word;
    logic                      r_word_valid;
    logic                      r_sat;

    logic signed [ACC_W:0]     w_smp_ext;
    logic signed [ACC_W:0]     w_sum_wide;
    logic signed [ACC_W-1:0]   w_sum;
    logic                      w_clip;
    logic                      w_bit;
    logic [CHIPS-1:0]          w_shift_next;

    // Samples only contribute when flagged valid; the strobe-cycle sample
    // is part of the window being dumped.
    assign w_smp_ext  = bus.smp_valid
                      ? {{(ACC_W+1-DATA_W){bus.sample[DATA_W-1]}}, bus.sample}
                      : '0;
    assign w_sum_wide = {r_acc[ACC_W-1], r_acc} + w_smp_ext;

    always_comb begin
        w_sum  = w_sum_wide[ACC_W-1:0];
        w_clip = 1'b0;
        if (w_sum_wide > c_MAX) begin
            w_sum  = c_MAX[ACC_W-1:0];
            w_clip = 1'b1;
        end else if (w_sum_wide < c_MIN) begin
            w_sum  = c_MIN[ACC_W-1:0];
            w_clip = 1'b1;
        end
    end

    // Strictly positive slices to 1; zero slices to 0.
    assign w_bit        = ~w_sum[ACC_W-1] & (|w_sum);
    assign w_shift_next = {r_shift[CHIPS-2:0], w_bit};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_shift      <= '0;
            r_chip       <= 1'b0;
            r_chip_valid <= 1'b0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
            r_sat        <= 1'b0;
        end else begin
            r_chip_valid <= 1'b0;
            r_word_valid <= 1'b0;
            if (!bus.enable) begin
                // Disable overrides everything: partial word is dropped.
                r_state <= S_IDLE;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_shift <= '0;
                r_sat   <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_ARM;
                    end
                    S_ARM, S_RUN: begin
                        if (bus.realign) begin
                            // Realign wins over a coincident strobe.
                            r_state <= S_ARM;
                            r_acc   <= '0;
                            r_cnt   <= '0;
                            r_shift <= '0;
                            r_sat   <= 1'b0;
                        end else begin
                            if (w_clip) begin
                                r_sat <= 1'b1;
                            end
                            if (bus.en_dec) begin
                                r_acc <= '0;
                                if (r_state == S_ARM) begin
                                    // Window began mid-chip: discard it.
                                    r_state <= S_RUN;
                                end else begin
                                    r_chip       <= w_bit;
                                    r_chip_valid <= 1'b1;
                                    r_shift      <= w_shift_next;
                                    if (r_cnt == c_LAST) begin
                                        r_cnt        <= '0;
                                        r_word       <= w_shift_next;
                                        r_word_valid <= 1'b1;
                                    end else begin
                                        r_cnt <= r_cnt + 1'b1;
                                    end
                                end
                            end else begin
                                r_acc <= w_sum;
                            end
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.chip       = r_chip;
    assign bus.chip_valid = r_chip_valid;
    assign bus.word       = r_word;
    assign bus.word_valid = r_word_valid;
    assign bus.sat        = r_sat;

endmodule

`default_nettype wire
